// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock-alive monitor.
// State encodings match the slow-control register map.
package clk_mon_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_INIT    = 2'd0,
    ST_GOOD    = 2'd1,
    ST_SUSPECT = 2'd2,
    ST_LOST    = 2'd3
  } mon_st_t;

endpackage

// File: rtl/clk_mon_timeout.sv
// Stall watchdog for the measurement stream.
// Emits hit on the last cycle of a window with no valid strobe.
module clk_mon_timeout #(
  parameter int TIMEOUT = 300_000_000,
  parameter int TO_W    = 29
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  output logic hit
);

  logic [TO_W-1:0] toCnt;

  assign hit = (toCnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      toCnt <= '0;
    end else if (clr || hit) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_alive_monitor.sv
// Qualifies gate-window counts against a frequency window,
// debounces the verdict and raises a sticky loss alarm.
module clk_alive_monitor
  import clk_mon_pkg::*;
#(
  parameter int              CNT_W   = 24,
  parameter logic [CNT_W-1:0] FMIN   = 24'd79_000,
  parameter logic [CNT_W-1:0] FMAX   = 24'd81_000,
  parameter int              GOOD_N  = 2,
  parameter int              BAD_N   = 2,
  parameter int              TIMEOUT = 300_000_000,
  parameter int              TO_W    = 29,
  parameter int              LCNT_W  = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              freq_valid,
  input  logic [CNT_W-1:0]  freq_count,
  input  logic              alarm_clr,
  output logic              clk_ok,
  output logic              alarm,
  output logic              irq,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  last_freq,
  output logic [LCNT_W-1:0] loss_cnt
);

  localparam int GC_W = $clog2(GOOD_N + 1);
  localparam int BC_W = $clog2(BAD_N + 1);
  localparam logic [GC_W-1:0] GOOD_LIM = GC_W'(GOOD_N);
  localparam logic [BC_W-1:0] BAD_LIM  = BC_W'(BAD_N);

  mon_st_t           stateQ, stateNxt;
  logic [GC_W-1:0]   goodCnt, goodNxt, goodInc;
  logic [BC_W-1:0]   badCnt, badNxt, badInc;
  logic              timeoutHit, inRange, bad;
  logic              lostEntry, recover;
  logic              clkOkQ, clkOkNxt;
  logic              alarmQ, alarmNxt;
  logic              irqQ, irqNxt;
  logic [CNT_W-1:0]  lastQ, lastNxt;
  logic [LCNT_W-1:0] lossQ, lossNxt;

  clk_mon_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) uTimeout (
    .clk  (iCLK),
    .rstN (iRST_N),
    .clr  (freq_valid),
    .hit  (timeoutHit)
  );

  // A timeout coinciding with a real sample is ignored
  assign inRange = freq_valid && (freq_count >= FMIN) && (freq_count <= FMAX);
  assign bad     = (freq_valid || timeoutHit) && !inRange;
  assign goodInc = goodCnt + 1'b1;
  assign badInc  = badCnt + 1'b1;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ  <= ST_INIT;
      goodCnt <= '0;
      badCnt  <= '0;
      clkOkQ  <= 1'b0;
      alarmQ  <= 1'b0;
      irqQ    <= 1'b0;
      lastQ   <= '0;
      lossQ   <= '0;
    end else begin
      stateQ  <= stateNxt;
      goodCnt <= goodNxt;
      badCnt  <= badNxt;
      clkOkQ  <= clkOkNxt;
      alarmQ  <= alarmNxt;
      irqQ    <= irqNxt;
      lastQ   <= lastNxt;
      lossQ   <= lossNxt;
    end
  end

  always_comb begin
    stateNxt  = stateQ;
    goodNxt   = goodCnt;
    badNxt    = badCnt;
    lostEntry = 1'b0;
    recover   = 1'b0;
    case (stateQ)
      ST_INIT: begin
        unique case (1'b1)
          inRange: begin
            if (goodInc == GOOD_LIM) begin
              stateNxt = ST_GOOD;
              goodNxt  = '0;
            end else begin
              goodNxt = goodInc;
            end
          end
          bad:     goodNxt = '0;
          default: ;
        endcase
      end
      ST_GOOD: begin
        if (bad) begin
          if (BAD_N == 1) begin
            lostEntry = 1'b1;
          end else begin
            stateNxt = ST_SUSPECT;
            badNxt   = BC_W'(1);
          end
        end
      end
      ST_SUSPECT: begin
        unique case (1'b1)
          inRange: begin
            stateNxt = ST_GOOD;
            badNxt   = '0;
          end
          bad: begin
            if (badInc == BAD_LIM) begin
              lostEntry = 1'b1;
            end else begin
              badNxt = badInc;
            end
          end
          default: ;
        endcase
      end
      ST_LOST: begin
        unique case (1'b1)
          inRange: begin
            if (goodInc == GOOD_LIM) begin
              stateNxt = ST_GOOD;
              goodNxt  = '0;
              recover  = 1'b1;
            end else begin
              goodNxt = goodInc;
            end
          end
          bad:     goodNxt = '0;
          default: ;
        endcase
      end
      default: begin
        stateNxt = ST_INIT;
        goodNxt  = '0;
        badNxt   = '0;
      end
    endcase
    if (lostEntry) begin
      stateNxt = ST_LOST;
      goodNxt  = '0;
      badNxt   = '0;
    end
  end

  // Set beats clear when both land in the same cycle
  always_comb begin
    clkOkNxt = (stateNxt == ST_GOOD) || (stateNxt == ST_SUSPECT);
    irqNxt   = lostEntry || recover;
    alarmNxt = alarmQ;
    if (lostEntry) begin
      alarmNxt = 1'b1;
    end else if (alarm_clr) begin
      alarmNxt = 1'b0;
    end
    lossNxt = lossQ;
    if (lostEntry && (lossQ != '1)) begin
      lossNxt = lossQ + 1'b1;
    end
    lastNxt = freq_valid ? freq_count : lastQ;
  end

  assign clk_ok    = clkOkQ;
  assign alarm     = alarmQ;
  assign irq       = irqQ;
  assign state     = stateQ;
  assign last_freq = lastQ;
  assign loss_cnt  = lossQ;

endmodule
